// File: rtl/clk_rst_seq_pkg.sv
// Shared definitions for the MMCM reset-and-lock sequencer: state encoding
// and the sizing helper for the shared timing counter.
package clk_rst_seq_pkg;

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_REL    = 3'd3,
    S_RUN    = 3'd4,
    S_FAIL   = 3'd5
  } state_t;

  // The counter only has to reach (longest interval - 1), so $clog2 of the
  // longest interval is enough; never narrower than one bit.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for slow level signals crossing into clk.
// Both flops clear to 0 on the synchronous reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/clk_rst_seq.sv
// MMCM reset/lock sequencer: pulses mmcm_rst, waits for a stable lock with
// bounded retries, then releases the downstream reset domains one by one.
module clk_rst_seq
  import clk_rst_seq_pkg::*;
#(
  parameter int RST_CYC    = 16,
  parameter int LOCK_TO    = 65536,
  parameter int STABLE_CYC = 1024,
  parameter int N_DOM      = 3,
  parameter int STAGE_CYC  = 64,
  parameter int MAX_RETRY  = 7
) (
  input  logic                           clki,
  input  logic                           rsti,
  input  logic                           mmcm_locked,
  input  logic                           sw_rst,
  input  logic                           clr_fail,
  output logic                           mmcm_rst,
  output logic [N_DOM-1:0]               dom_rst,
  output logic                           ready,
  output logic                           fail,
  output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt,
  output logic [2:0]                     state_o
);

  localparam int CNT_W = cnt_width(RST_CYC, LOCK_TO, STABLE_CYC, STAGE_CYC);
  localparam int STG_W = (N_DOM > 1) ? $clog2(N_DOM) : 1;
  localparam int RTY_W = $clog2(MAX_RETRY + 1);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [STG_W-1:0]   stg, stg_n;
  logic [N_DOM-1:0]   dom_n;
  logic [RTY_W-1:0]   retry_n;
  logic               cnt_clr;
  logic               lock_s;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk (clki),
    .rst (rsti),
    .d   (mmcm_locked),
    .q   (lock_s)
  );

  always_comb begin
    state_n = state;
    cnt_clr = 1'b0;
    stg_n   = stg;
    dom_n   = dom_rst;
    retry_n = retry_cnt;

    case (state)
      S_RST: begin
        if (cnt == CNT_W'(RST_CYC - 1)) state_n = S_WAIT;
      end
      S_WAIT: begin
        if (lock_s) begin
          state_n = S_STABLE;
        end else if (cnt == CNT_W'(LOCK_TO - 1)) begin
          retry_n = retry_cnt + 1'b1;
          state_n = (retry_cnt == RTY_W'(MAX_RETRY - 1)) ? S_FAIL : S_RST;
        end
      end
      S_STABLE: begin
        if (!lock_s) begin
          state_n = S_WAIT;
        end else if (cnt == CNT_W'(STABLE_CYC - 1)) begin
          state_n = S_REL;
          stg_n   = '0;
        end
      end
      S_REL: begin
        if (cnt == CNT_W'(STAGE_CYC - 1)) begin
          cnt_clr = 1'b1;
          for (int i = 0; i < N_DOM; i++) begin
            if (i == int'(stg)) dom_n[i] = 1'b0;
          end
          stg_n = stg + 1'b1;
          if (int'(stg) == N_DOM - 1) state_n = S_RUN;
        end
      end
      S_RUN: begin
      end
      S_FAIL: begin
        if (clr_fail) begin
          state_n = S_RST;
          retry_n = '0;
        end
      end
      default: state_n = S_RST;
    endcase

    // Software restart outranks lock loss; both are meaningless in FAIL.
    if (state != S_FAIL && sw_rst) begin
      state_n = S_RST;
      cnt_clr = 1'b1;
    end else if ((state == S_REL || state == S_RUN) && !lock_s) begin
      state_n = S_RST;
    end

    if (state_n == S_RUN && state != S_RUN) retry_n = '0;
    if (state_n == S_RST || state_n == S_FAIL) dom_n = '1;

    if (state_n != state || cnt_clr)
      cnt_n = '0;
    else if (state == S_RST || state == S_WAIT || state == S_STABLE || state == S_REL)
      cnt_n = cnt + 1'b1;
    else
      cnt_n = cnt;
  end

  // Output flags are decoded from the next state so they change in the same
  // register update as the state itself.
  always_ff @(posedge clki) begin
    if (rsti) begin
      state     <= S_RST;
      cnt       <= '0;
      stg       <= '0;
      dom_rst   <= '1;
      mmcm_rst  <= 1'b1;
      ready     <= 1'b0;
      fail      <= 1'b0;
      retry_cnt <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      stg       <= stg_n;
      dom_rst   <= dom_n;
      mmcm_rst  <= (state_n == S_RST) || (state_n == S_FAIL);
      ready     <= (state_n == S_RUN);
      fail      <= (state_n == S_FAIL);
      retry_cnt <= retry_n;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_clk_rst_seq.sv
// Directed bench for clk_rst_seq with short timing parameters; expected
// values are hand-derived cycle positions relative to each stimulus event.
module tb_clk_rst_seq;

  logic       clki = 1'b0;
  logic       rsti = 1'b1;
  logic       mmcm_locked = 1'b0;
  logic       sw_rst = 1'b0;
  logic       clr_fail = 1'b0;
  logic       mmcm_rst;
  logic [2:0] dom_rst;
  logic       ready;
  logic       fail;
  logic [1:0] retry_cnt;
  logic [2:0] state_o;

  int n_cmp = 0;
  int n_bad = 0;

  clk_rst_seq #(
    .RST_CYC(4), .LOCK_TO(50), .STABLE_CYC(8),
    .N_DOM(3), .STAGE_CYC(4), .MAX_RETRY(2)
  ) dut (
    .clki(clki), .rsti(rsti), .mmcm_locked(mmcm_locked),
    .sw_rst(sw_rst), .clr_fail(clr_fail), .mmcm_rst(mmcm_rst),
    .dom_rst(dom_rst), .ready(ready), .fail(fail),
    .retry_cnt(retry_cnt), .state_o(state_o)
  );

  always #5 clki = ~clki;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clki);
  endtask

  task automatic do_reset();
    rsti = 1'b1;
    mmcm_locked = 1'b0;
    step(2);
    rsti = 1'b0;
  endtask

  task automatic test_reset();
    rsti = 1'b1;
    mmcm_locked = 1'b0;
    step(2);
    n_cmp++; if (mmcm_rst !== 1'b1)   begin n_bad++; $display("FAIL rst_mmcm: got %b want 1", mmcm_rst); end
    n_cmp++; if (dom_rst !== 3'b111)  begin n_bad++; $display("FAIL rst_dom: got %b want 111", dom_rst); end
    n_cmp++; if (ready !== 1'b0)      begin n_bad++; $display("FAIL rst_ready: got %b want 0", ready); end
    n_cmp++; if (fail !== 1'b0)       begin n_bad++; $display("FAIL rst_fail: got %b want 0", fail); end
    n_cmp++; if (retry_cnt !== 2'd0)  begin n_bad++; $display("FAIL rst_retry: got %0d want 0", retry_cnt); end
    n_cmp++; if (state_o !== 3'd0)    begin n_bad++; $display("FAIL rst_state: got %0d want 0", state_o); end
    rsti = 1'b0;
  endtask

  task automatic test_nominal();
    int hi;
    hi = 1;
    for (int i = 0; i < 20 && mmcm_rst; i++) begin
      step(1);
      if (mmcm_rst) hi++;
    end
    n_cmp++; if (hi !== 4)           begin n_bad++; $display("FAIL nom_rst_len: got %0d want 4", hi); end
    n_cmp++; if (state_o !== 3'd1)   begin n_bad++; $display("FAIL nom_wait: got %0d want 1", state_o); end
    step(10);
    mmcm_locked = 1'b1;
    step(3);
    n_cmp++; if (state_o !== 3'd2)   begin n_bad++; $display("FAIL nom_stable: got %0d want 2", state_o); end
    step(8);
    n_cmp++; if (state_o !== 3'd3)   begin n_bad++; $display("FAIL nom_rel: got %0d want 3", state_o); end
    n_cmp++; if (dom_rst !== 3'b111) begin n_bad++; $display("FAIL nom_dom111: got %b want 111", dom_rst); end
    step(3);
    n_cmp++; if (dom_rst !== 3'b111) begin n_bad++; $display("FAIL nom_dom111_hold: got %b want 111", dom_rst); end
    step(1);
    n_cmp++; if (dom_rst !== 3'b110) begin n_bad++; $display("FAIL nom_dom110: got %b want 110", dom_rst); end
    step(4);
    n_cmp++; if (dom_rst !== 3'b100) begin n_bad++; $display("FAIL nom_dom100: got %b want 100", dom_rst); end
    step(3);
    n_cmp++; if (ready !== 1'b0)     begin n_bad++; $display("FAIL nom_ready_early: got %b want 0", ready); end
    step(1);
    n_cmp++; if (dom_rst !== 3'b000) begin n_bad++; $display("FAIL nom_dom000: got %b want 000", dom_rst); end
    n_cmp++; if (ready !== 1'b1)     begin n_bad++; $display("FAIL nom_ready: got %b want 1", ready); end
    n_cmp++; if (state_o !== 3'd4)   begin n_bad++; $display("FAIL nom_run: got %0d want 4", state_o); end
    n_cmp++; if (retry_cnt !== 2'd0) begin n_bad++; $display("FAIL nom_retry: got %0d want 0", retry_cnt); end
  endtask

  task automatic test_timeout_fail();
    do_reset();
    step(4);
    n_cmp++; if (state_o !== 3'd1)   begin n_bad++; $display("FAIL to_wait1: got %0d want 1", state_o); end
    step(49);
    n_cmp++; if (state_o !== 3'd1 || retry_cnt !== 2'd0) begin n_bad++; $display("FAIL to_wait1_end: got state %0d retry %0d want 1/0", state_o, retry_cnt); end
    step(1);
    n_cmp++; if (state_o !== 3'd0)   begin n_bad++; $display("FAIL to_retry1_state: got %0d want 0", state_o); end
    n_cmp++; if (retry_cnt !== 2'd1) begin n_bad++; $display("FAIL to_retry1: got %0d want 1", retry_cnt); end
    n_cmp++; if (mmcm_rst !== 1'b1)  begin n_bad++; $display("FAIL to_retry1_mmcm: got %b want 1", mmcm_rst); end
    step(4);
    n_cmp++; if (state_o !== 3'd1)   begin n_bad++; $display("FAIL to_wait2: got %0d want 1", state_o); end
    step(49);
    n_cmp++; if (state_o !== 3'd1)   begin n_bad++; $display("FAIL to_wait2_end: got %0d want 1", state_o); end
    step(1);
    n_cmp++; if (state_o !== 3'd5)   begin n_bad++; $display("FAIL to_fail_state: got %0d want 5", state_o); end
    n_cmp++; if (fail !== 1'b1)      begin n_bad++; $display("FAIL to_fail_flag: got %b want 1", fail); end
    n_cmp++; if (retry_cnt !== 2'd2) begin n_bad++; $display("FAIL to_retry2: got %0d want 2", retry_cnt); end
    n_cmp++; if (mmcm_rst !== 1'b1 || dom_rst !== 3'b111 || ready !== 1'b0) begin n_bad++; $display("FAIL to_fail_outs: got mmcm %b dom %b ready %b want 1/111/0", mmcm_rst, dom_rst, ready); end
    sw_rst = 1'b1;
    step(1);
    sw_rst = 1'b0;
    step(1);
    n_cmp++; if (state_o !== 3'd5 || fail !== 1'b1) begin n_bad++; $display("FAIL to_swrst_ignored: got state %0d fail %b want 5/1", state_o, fail); end
    clr_fail = 1'b1;
    step(1);
    clr_fail = 1'b0;
    n_cmp++; if (state_o !== 3'd0)   begin n_bad++; $display("FAIL to_clr_state: got %0d want 0", state_o); end
    n_cmp++; if (retry_cnt !== 2'd0) begin n_bad++; $display("FAIL to_clr_retry: got %0d want 0", retry_cnt); end
    n_cmp++; if (fail !== 1'b0)      begin n_bad++; $display("FAIL to_clr_fail: got %b want 0", fail); end
  endtask

  task automatic test_glitch();
    do_reset();
    step(4);
    mmcm_locked = 1'b1;
    step(5);
    mmcm_locked = 1'b0;
    step(1);
    mmcm_locked = 1'b1;
    step(1);
    n_cmp++; if (state_o !== 3'd2)   begin n_bad++; $display("FAIL gl_stable5: got %0d want 2", state_o); end
    step(1);
    n_cmp++; if (state_o !== 3'd1)   begin n_bad++; $display("FAIL gl_back_wait: got %0d want 1", state_o); end
    n_cmp++; if (retry_cnt !== 2'd0) begin n_bad++; $display("FAIL gl_retry: got %0d want 0", retry_cnt); end
    step(1);
    n_cmp++; if (state_o !== 3'd2)   begin n_bad++; $display("FAIL gl_restable: got %0d want 2", state_o); end
    step(7);
    n_cmp++; if (state_o !== 3'd2)   begin n_bad++; $display("FAIL gl_stable_full: got %0d want 2", state_o); end
    step(1);
    n_cmp++; if (state_o !== 3'd3)   begin n_bad++; $display("FAIL gl_rel: got %0d want 3", state_o); end
    step(4);
    n_cmp++; if (dom_rst !== 3'b110) begin n_bad++; $display("FAIL gl_dom110: got %b want 110", dom_rst); end
    step(8);
    n_cmp++; if (dom_rst !== 3'b000 || ready !== 1'b1) begin n_bad++; $display("FAIL gl_run: got dom %b ready %b want 000/1", dom_rst, ready); end
  endtask

  task automatic test_lock_loss();
    int hi;
    mmcm_locked = 1'b0;
    step(2);
    n_cmp++; if (dom_rst !== 3'b000 || ready !== 1'b1) begin n_bad++; $display("FAIL ll_still_run: got dom %b ready %b want 000/1", dom_rst, ready); end
    step(1);
    n_cmp++; if (dom_rst !== 3'b111) begin n_bad++; $display("FAIL ll_dom: got %b want 111", dom_rst); end
    n_cmp++; if (ready !== 1'b0)     begin n_bad++; $display("FAIL ll_ready: got %b want 0", ready); end
    n_cmp++; if (state_o !== 3'd0)   begin n_bad++; $display("FAIL ll_state: got %0d want 0", state_o); end
    hi = 0;
    if (mmcm_rst) hi = 1;
    for (int i = 0; i < 20 && mmcm_rst; i++) begin
      step(1);
      if (mmcm_rst) hi++;
    end
    n_cmp++; if (hi !== 4)           begin n_bad++; $display("FAIL ll_rst_len: got %0d want 4", hi); end
    mmcm_locked = 1'b1;
    step(3);
    n_cmp++; if (state_o !== 3'd2)   begin n_bad++; $display("FAIL ll_stable: got %0d want 2", state_o); end
    step(8);
    n_cmp++; if (state_o !== 3'd3)   begin n_bad++; $display("FAIL ll_rel: got %0d want 3", state_o); end
    step(12);
    n_cmp++; if (dom_rst !== 3'b000 || ready !== 1'b1) begin n_bad++; $display("FAIL ll_rerun: got dom %b ready %b want 000/1", dom_rst, ready); end
  endtask

  task automatic test_sw_rst();
    do_reset();
    step(4);
    mmcm_locked = 1'b1;
    step(15);
    n_cmp++; if (dom_rst !== 3'b110) begin n_bad++; $display("FAIL sw_pre: got %b want 110", dom_rst); end
    sw_rst = 1'b1;
    step(1);
    sw_rst = 1'b0;
    n_cmp++; if (dom_rst !== 3'b111) begin n_bad++; $display("FAIL sw_dom: got %b want 111", dom_rst); end
    n_cmp++; if (state_o !== 3'd0 || ready !== 1'b0 || mmcm_rst !== 1'b1) begin n_bad++; $display("FAIL sw_state: got state %0d ready %b mmcm %b want 0/0/1", state_o, ready, mmcm_rst); end
    step(4);
    n_cmp++; if (state_o !== 3'd1 || mmcm_rst !== 1'b0) begin n_bad++; $display("FAIL sw_wait: got state %0d mmcm %b want 1/0", state_o, mmcm_rst); end
    step(1);
    n_cmp++; if (state_o !== 3'd2)   begin n_bad++; $display("FAIL sw_stable: got %0d want 2", state_o); end
    step(8);
    n_cmp++; if (state_o !== 3'd3)   begin n_bad++; $display("FAIL sw_rel: got %0d want 3", state_o); end
    step(12);
    n_cmp++; if (dom_rst !== 3'b000 || ready !== 1'b1) begin n_bad++; $display("FAIL sw_run: got dom %b ready %b want 000/1", dom_rst, ready); end
  endtask

  task automatic test_rsti_rel();
    do_reset();
    step(4);
    mmcm_locked = 1'b1;
    step(12);
    n_cmp++; if (state_o !== 3'd3)   begin n_bad++; $display("FAIL rr_in_rel: got %0d want 3", state_o); end
    rsti = 1'b1;
    step(1);
    n_cmp++; if (mmcm_rst !== 1'b1 || dom_rst !== 3'b111 || ready !== 1'b0 || fail !== 1'b0 || retry_cnt !== 2'd0 || state_o !== 3'd0) begin
      n_bad++;
      $display("FAIL rr_reset_vals: got mmcm %b dom %b ready %b fail %b retry %0d state %0d want 1/111/0/0/0/0",
               mmcm_rst, dom_rst, ready, fail, retry_cnt, state_o);
    end
    rsti = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_timeout_fail();
    test_glitch();
    test_lock_loss();
    test_sw_rst();
    test_rsti_rel();
    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
